// File: rtl/mem_rr_arbiter.sv
// Round-robin front end sharing one single-port memory bus among N_CH requesters.
// Registered command stage; read data is routed back by a fixed-latency channel-tag pipeline.
module mem_rr_arbiter #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_CH-1:0]           chWe,
  input  logic [N_CH-1:0]           chRd,
  input  logic [N_CH*PC_WIDTH-1:0]  chAdr,
  input  logic [N_CH*REG_WIDTH-1:0] chwrData,
  output logic [N_CH-1:0]           chGnt,
  output logic [N_CH-1:0]           chrdValid,
  output logic [REG_WIDTH-1:0]      chrdData,
  output logic                      memWe,
  output logic                      memRd,
  output logic [PC_WIDTH-1:0]       memAdr,
  output logic [REG_WIDTH-1:0]      memwrData,
  input  logic [REG_WIDTH-1:0]      memrdData
);

  localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gntIdx;
  logic [PTR_W-1:0] candIdx;
  logic             gntAny;
  logic             gntWe;
  logic             gntRdOnly;
  logic [N_CH-1:0]  req;

  logic [RD_LAT:0]  tagV;
  logic [PTR_W-1:0] tagCh [RD_LAT+1];

  assign req = chWe | chRd;

  // First requester at or after ptr, wrapping; nothing is granted while in reset.
  always_comb begin
    gntAny  = 1'b0;
    gntIdx  = '0;
    candIdx = '0;
    chGnt   = '0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      candIdx = PTR_W'((32'(ptr) + off) % N_CH);
      if (!gntAny && resetn && req[candIdx]) begin
        gntAny = 1'b1;
        gntIdx = candIdx;
      end
    end
    if (gntAny) chGnt[gntIdx] = 1'b1;
  end

  always_comb begin
    gntWe     = gntAny & chWe[gntIdx];
    gntRdOnly = gntAny & chRd[gntIdx] & ~chWe[gntIdx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr       <= '0;
      memWe     <= 1'b0;
      memRd     <= 1'b0;
      memAdr    <= '0;
      memwrData <= '0;
    end else begin
      memWe <= gntWe;
      memRd <= gntRdOnly;
      if (gntAny) begin
        ptr       <= (gntIdx == PTR_W'(N_CH - 1)) ? '0 : gntIdx + 1'b1;
        memAdr    <= chAdr[32'(gntIdx) * PC_WIDTH +: PC_WIDTH];
        memwrData <= chwrData[32'(gntIdx) * REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  // Tag pushed at the grant edge surfaces RD_LAT+1 edges later, aligned with memrdData.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tagV      <= '0;
      chrdValid <= '0;
      chrdData  <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) tagCh[i] <= '0;
    end else begin
      tagV     <= {tagV[RD_LAT-1:0], gntRdOnly};
      tagCh[0] <= gntIdx;
      for (int unsigned i = 1; i <= RD_LAT; i++) tagCh[i] <= tagCh[i-1];
      chrdValid <= '0;
      if (tagV[RD_LAT]) begin
        chrdValid[tagCh[RD_LAT]] <= 1'b1;
        chrdData                 <= memrdData;
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: three instances (4ch/lat2, 2ch/lat1, 8ch/lat4) run in
// lockstep against a behavioural round-robin/return-queue model with a fixed-function memory.
module tb_mem_rr_arbiter;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [7:0]   tWe [NI];
  logic [7:0]   tRd [NI];
  logic [31:0]  tAdr [NI][8];
  logic [31:0]  tWd  [NI][8];
  logic [255:0] adrF [NI];
  logic [255:0] wdF  [NI];

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 8; i++) begin
        adrF[k][i*32 +: 32] = tAdr[k][i];
        wdF[k][i*32 +: 32]  = tWd[k][i];
      end
    end
  end

  logic [3:0]  gA, vA;
  logic [1:0]  gB, vB;
  logic [7:0]  gC, vC;
  logic        oWe [NI];
  logic        oRd [NI];
  logic [31:0] oAdr [NI];
  logic [31:0] oWd [NI];
  logic [31:0] oRdD [NI];
  logic [31:0] memRdD [NI];

  mem_rr_arbiter #(.PC_WIDTH(32), .REG_WIDTH(32), .N_CH(4), .RD_LAT(2)) dutA (
    .clk(clk), .resetn(resetn), .chWe(tWe[0][3:0]), .chRd(tRd[0][3:0]),
    .chAdr(adrF[0][127:0]), .chwrData(wdF[0][127:0]), .chGnt(gA), .chrdValid(vA),
    .chrdData(oRdD[0]), .memWe(oWe[0]), .memRd(oRd[0]), .memAdr(oAdr[0]),
    .memwrData(oWd[0]), .memrdData(memRdD[0]));

  mem_rr_arbiter #(.PC_WIDTH(32), .REG_WIDTH(32), .N_CH(2), .RD_LAT(1)) dutB (
    .clk(clk), .resetn(resetn), .chWe(tWe[1][1:0]), .chRd(tRd[1][1:0]),
    .chAdr(adrF[1][63:0]), .chwrData(wdF[1][63:0]), .chGnt(gB), .chrdValid(vB),
    .chrdData(oRdD[1]), .memWe(oWe[1]), .memRd(oRd[1]), .memAdr(oAdr[1]),
    .memwrData(oWd[1]), .memrdData(memRdD[1]));

  mem_rr_arbiter #(.PC_WIDTH(32), .REG_WIDTH(32), .N_CH(8), .RD_LAT(4)) dutC (
    .clk(clk), .resetn(resetn), .chWe(tWe[2]), .chRd(tRd[2]),
    .chAdr(adrF[2]), .chwrData(wdF[2]), .chGnt(gC), .chrdValid(vC),
    .chrdData(oRdD[2]), .memWe(oWe[2]), .memRd(oRd[2]), .memAdr(oAdr[2]),
    .memwrData(oWd[2]), .memrdData(memRdD[2]));

  function automatic logic [31:0] memFn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  // Memory: samples memRd/memAdr at the edge, data appears RD_LAT cycles after memRd was visible.
  logic [31:0] pipe [NI][4];
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      for (int j = 3; j > 0; j--) pipe[k][j] <= pipe[k][j-1];
      pipe[k][0] <= oRd[k] ? memFn(oAdr[k]) : 32'hBAD0BAD0;
    end
  end
  assign memRdD[0] = pipe[0][1];
  assign memRdD[1] = pipe[1][0];
  assign memRdD[2] = pipe[2][3];

  function automatic int nch(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 8;
  endfunction
  function automatic int lat(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction
  function automatic logic [31:0] gntOf(input int k);
    return (k == 0) ? 32'(gA) : (k == 1) ? 32'(gB) : 32'(gC);
  endfunction
  function automatic logic [31:0] rvOf(input int k);
    return (k == 0) ? 32'(vA) : (k == 1) ? 32'(vB) : 32'(vC);
  endfunction

  typedef struct {
    int          inst;
    int          ch;
    logic [31:0] data;
    int          due;
  } ret_t;

  ret_t        retQ [$];
  int          mPtr [NI];
  logic        mWe [NI];
  logic        mRd [NI];
  logic [31:0] mAdr [NI];
  logic [31:0] mWd [NI];
  int          gSel [NI];
  int          edgeN;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkZero(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s.gnt%0d", tag, k), gntOf(k), 32'd0);
      chk($sformatf("%s.rv%0d", tag, k), rvOf(k), 32'd0);
      chk($sformatf("%s.rdData%0d", tag, k), oRdD[k], 32'd0);
      chk($sformatf("%s.memWe%0d", tag, k), 32'(oWe[k]), 32'd0);
      chk($sformatf("%s.memRd%0d", tag, k), 32'(oRd[k]), 32'd0);
      chk($sformatf("%s.memAdr%0d", tag, k), oAdr[k], 32'd0);
      chk($sformatf("%s.memwrData%0d", tag, k), oWd[k], 32'd0);
    end
  endtask

  // One clock for all instances: predict grants, cross the edge, check command and read return.
  task automatic cycleAll(input bit randLoad);
    int n, g, fi, r;
    logic [31:0] expV;
    #2;
    for (int k = 0; k < NI; k++) begin
      n = nch(k);
      g = -1;
      for (int off = 0; off < n; off++) begin
        int i;
        i = (mPtr[k] + off) % n;
        if (g < 0 && (tWe[k][i] | tRd[k][i])) g = i;
      end
      chk($sformatf("gnt%0d", k), gntOf(k), (g >= 0) ? (32'd1 << g) : 32'd0);
      gSel[k] = g;
      if (g >= 0) begin
        mPtr[k] = (g + 1) % n;
        mWe[k]  = tWe[k][g];
        mRd[k]  = tRd[k][g] & ~tWe[k][g];
        mAdr[k] = tAdr[k][g];
        mWd[k]  = tWd[k][g];
        if (mRd[k]) retQ.push_back('{inst: k, ch: g, data: memFn(mAdr[k]), due: edgeN + 2 + lat(k)});
      end else begin
        mWe[k] = 1'b0;
        mRd[k] = 1'b0;
      end
    end
    @(posedge clk);
    edgeN++;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("memWe%0d", k), 32'(oWe[k]), 32'(mWe[k]));
      chk($sformatf("memRd%0d", k), 32'(oRd[k]), 32'(mRd[k]));
      chk($sformatf("memAdr%0d", k), oAdr[k], mAdr[k]);
      chk($sformatf("memwrData%0d", k), oWd[k], mWd[k]);
      fi = -1;
      for (int q = 0; q < retQ.size(); q++)
        if (fi < 0 && retQ[q].inst == k && retQ[q].due == edgeN) fi = q;
      expV = (fi >= 0) ? (32'd1 << retQ[fi].ch) : 32'd0;
      chk($sformatf("rdValid%0d", k), rvOf(k), expV);
      if (fi >= 0) begin
        chk($sformatf("rdData%0d", k), oRdD[k], retQ[fi].data);
        retQ.delete(fi);
      end
      if (gSel[k] >= 0) begin
        tWe[k][gSel[k]] = 1'b0;
        tRd[k][gSel[k]] = 1'b0;
      end
      if (randLoad) begin
        for (int i = 0; i < nch(k); i++) begin
          if (!(tWe[k][i] | tRd[k][i]) && $urandom_range(0, 2) != 0) begin
            r = $urandom_range(0, 3);
            tWe[k][i]  = (r == 0 || r == 3);
            tRd[k][i]  = (r != 0);
            tAdr[k][i] = $urandom & 32'h3FC;
            tWd[k][i]  = $urandom;
          end
        end
      end
    end
  endtask

  task automatic setReq(input int k, input int ch, input bit we, input bit rd,
                        input logic [31:0] adr, input logic [31:0] wd);
    tWe[k][ch]  = we;
    tRd[k][ch]  = rd;
    tAdr[k][ch] = adr;
    tWd[k][ch]  = wd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edgeN  = 0;
    resetn = 1'b0;
    for (int k = 0; k < NI; k++) begin
      tWe[k]  = '0;
      tRd[k]  = '0;
      mPtr[k] = 0;
      mWe[k]  = 1'b0;
      mRd[k]  = 1'b0;
      mAdr[k] = '0;
      mWd[k]  = '0;
      gSel[k] = -1;
      for (int i = 0; i < 8; i++) begin
        tAdr[k][i] = '0;
        tWd[k][i]  = '0;
      end
    end
    #12;
    chkZero("reset");
    resetn = 1'b1;

    // Single read: ch2 @0x100 returns 0xDEADBEEF four cycles after the grant.
    setReq(0, 2, 1'b0, 1'b1, 32'h100, 32'h0);
    repeat (7) cycleAll(1'b0);

    // Continuous requests from all four channels rotate through every channel.
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 4; i++) setReq(0, i, 1'b0, 1'b1, 32'h200 + 32'(c * 16 + i * 4), 32'h0);
      cycleAll(1'b0);
    end
    repeat (6) cycleAll(1'b0);

    // Back-to-back reads ch1/ch3 then a write from ch0.
    setReq(0, 1, 1'b0, 1'b1, 32'h10, 32'h0);
    cycleAll(1'b0);
    setReq(0, 3, 1'b0, 1'b1, 32'h20, 32'h0);
    cycleAll(1'b0);
    setReq(0, 0, 1'b1, 1'b0, 32'h30, 32'h55);
    cycleAll(1'b0);
    repeat (6) cycleAll(1'b0);

    // Write and read on one channel: write wins, no read return.
    setReq(0, 1, 1'b1, 1'b1, 32'h40, 32'hA5);
    cycleAll(1'b0);
    repeat (6) cycleAll(1'b0);

    // Randomized traffic on all three configurations.
    repeat (400) cycleAll(1'b1);

    // Asynchronous reset with reads in flight on every instance.
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < nch(k); i++) setReq(k, i, 1'b0, 1'b1, 32'h300 + 32'(i * 4), 32'h0);
    repeat (3) cycleAll(1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chkZero("asyncRst");
    @(posedge clk);
    @(posedge clk);
    #1;
    chkZero("rstHeld");
    #2;
    resetn = 1'b1;
    retQ.delete();
    for (int k = 0; k < NI; k++) begin
      mPtr[k] = 0;
      mAdr[k] = '0;
      mWd[k]  = '0;
      for (int i = 0; i < nch(k); i++) setReq(k, i, 1'b0, 1'b1, 32'h380 + 32'(i * 4), 32'h0);
    end
    repeat (20) cycleAll(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
